// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS core's multiply/divide unit: operation
// codes driven by decode and the iterative unit's FSM state values.
package mips_pkg;

    // Operation codes, as presented on the unit's op input
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM states of the iterative unit
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'b00;
    localparam state_t S_CALC = 2'b01;
    localparam state_t S_FIX  = 2'b10;

endpackage

// File: rtl/muldiv_datapath.sv
// One iteration of the shared multiply/divide accumulator.
// Multiply: shift-add on {partial, multiplier}; the low bit of the
//   accumulator selects whether the multiplicand is added to the top half.
// Divide: restoring division on {remainder, dividend}; each step shifts one
//   dividend bit into the remainder and shifts one quotient bit in at the bottom.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic               isDiv_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divTop;
    logic [WIDTH:0] divDiff;

    // Compute the next accumulator value for the selected operation
    always_comb begin
        mulSum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                  (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        divTop  = acc_i[2*WIDTH-1:WIDTH-1];
        divDiff = divTop - {1'b0, opnd_i};
        if (isDiv_i) begin
            // A clear borrow bit means the shifted remainder covers the divisor
            if (!divDiff[WIDTH]) begin
                acc_o = {divDiff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {divTop[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {mulSum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Operands are captured as magnitudes, the datapath produces one bit per
// cycle for WIDTH cycles, and the FIX state applies signs and writes HI/LO.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               isDiv_q, isDiv_d;
    logic               signA_q, signA_d;
    logic               signB_q, signB_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic               reqDiv;
    logic               reqSigned;
    logic               reqDivz;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [2*WIDTH-1:0] stepAcc;
    logic [2*WIDTH-1:0] prodSigned;
    logic [WIDTH-1:0]   fixHi;
    logic [WIDTH-1:0]   fixLo;

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .isDiv_i(isDiv_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (stepAcc)
    );

    // Decode the incoming request and form operand magnitudes for capture
    always_comb begin
        reqDiv    = (op == OP_DIV) || (op == OP_DIVU);
        reqSigned = (op == OP_MULT) || (op == OP_DIV);
        reqDivz   = reqDiv && (b == '0);
        absA      = (reqSigned && a[WIDTH-1]) ? -a : a;
        absB      = (reqSigned && b[WIDTH-1]) ? -b : b;
    end

    // Apply signs to the magnitude result; divide-by-zero bypasses sign fixing
    always_comb begin
        prodSigned = (signA_q ^ signB_q) ? -acc_q : acc_q;
        if (divz_q) begin
            fixHi = acc_q[2*WIDTH-1:WIDTH];
            fixLo = acc_q[WIDTH-1:0];
        end else if (isDiv_q) begin
            fixLo = (signA_q ^ signB_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            fixHi = signA_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            fixHi = prodSigned[2*WIDTH-1:WIDTH];
            fixLo = prodSigned[WIDTH-1:0];
        end
    end

    // FSM next-state, operand capture, iteration and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        isDiv_d = isDiv_q;
        signA_d = signA_q;
        signB_d = signB_q;
        divz_d  = divz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    isDiv_d = reqDiv;
                    signA_d = reqSigned && a[WIDTH-1];
                    signB_d = reqSigned && b[WIDTH-1];
                    divz_d  = reqDivz;
                    cnt_d   = '0;
                    if (reqDivz) begin
                        acc_d   = {a, {WIDTH{1'b1}}};
                        state_d = S_FIX;
                    end else if (reqDiv) begin
                        acc_d   = {{WIDTH{1'b0}}, absA};
                        opnd_d  = absB;
                        state_d = S_CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, absB};
                        opnd_d  = absA;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = stepAcc;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!cancel) begin
                    hi_d   = fixHi;
                    lo_d   = fixLo;
                    div0_d = divz_q;
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any partial result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            isDiv_q <= 1'b0;
            signA_q <= 1'b0;
            signB_q <= 1'b0;
            divz_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            isDiv_q <= isDiv_d;
            signA_q <= signA_d;
            signB_q <= signB_d;
            divz_q  <= divz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
